// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the IF/ID/EX pipeline: redirects, load-use bubbles, memory wait.
// Optional PIPELINE_HAZARD_PERF_EN adds stall/flush cycle counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned FLUSH_DEPTH    = 1,
   parameter int unsigned LOAD_LATENCY   = 1,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_take_branch,
   input  logic                      i_trap_req,
   input  logic                      i_trap_mret,
   input  logic                      i_mem_busy,
   input  logic                      i_ex_is_load,
   input  logic                      i_ex_regfile_we,
   input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd_addr,
   input  logic                      i_id_rs1_used,
   input  logic                      i_id_rs2_used,
   input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2_addr,
   output logic                      o_pc_hold,
   output logic                      o_ifid_stall,
   output logic                      o_ifid_flush,
   output logic                      o_idex_stall,
   output logic                      o_idex_flush,
`ifdef PIPELINE_HAZARD_PERF_EN
   output logic [31:0]               o_stall_cycles,
   output logic [31:0]               o_flush_cycles,
`endif
   output logic [1:0]                o_state
);

   localparam int unsigned MAX_CNT = (FLUSH_DEPTH > LOAD_LATENCY) ? FLUSH_DEPTH : LOAD_LATENCY;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_DEPTH - 1);
   localparam logic [CNT_W-1:0] LOAD_INIT  = CNT_W'(LOAD_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      REDIRECT   = 2'd1,
      LOAD_STALL = 2'd2,
      MEM_WAIT   = 2'd3
   } state_t;

   state_t           state, state_n, saved_state, saved_state_n, eff_state;
   logic [CNT_W-1:0] cnt, cnt_n, saved_cnt, saved_cnt_n, eff_cnt;
   logic             trap, haz;

   assign trap = i_trap_req | i_trap_mret;
   assign haz  = i_ex_is_load & i_ex_regfile_we & (i_ex_rd_addr != '0) &
                 ((i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr)) |
                  (i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr)));

   always_comb begin
      // Leaving MEM_WAIT behaves exactly like the saved state would have this cycle.
      eff_state = state;
      eff_cnt   = cnt;
      if (state == MEM_WAIT && !i_mem_busy) begin
         eff_state = saved_state;
         eff_cnt   = saved_cnt;
      end
      state_n       = eff_state;
      cnt_n         = eff_cnt;
      saved_state_n = saved_state;
      saved_cnt_n   = saved_cnt;
      o_pc_hold     = 1'b0;
      o_ifid_stall  = 1'b0;
      o_ifid_flush  = 1'b0;
      o_idex_stall  = 1'b0;
      o_idex_flush  = 1'b0;

      if (i_rst) begin
         o_pc_hold    = 1'b1;
         o_ifid_flush = 1'b1;
         o_idex_flush = 1'b1;
      end else if (trap || (!i_mem_busy && eff_state == RUN && i_take_branch)) begin
         o_ifid_flush = 1'b1;
         o_idex_flush = 1'b1;
         if (FLUSH_DEPTH > 1) begin
            state_n = REDIRECT;
            cnt_n   = FLUSH_INIT;
         end else begin
            state_n = RUN;
            cnt_n   = '0;
         end
      end else if (i_mem_busy) begin
         o_pc_hold    = 1'b1;
         o_ifid_stall = 1'b1;
         o_idex_stall = 1'b1;
         if (state != MEM_WAIT) begin
            saved_state_n = state;
            saved_cnt_n   = cnt;
         end
         state_n = MEM_WAIT;
         cnt_n   = cnt;
      end else begin
         unique case (eff_state)
            RUN: begin
               if (haz) begin
                  o_pc_hold    = 1'b1;
                  o_ifid_stall = 1'b1;
                  o_idex_flush = 1'b1;
                  if (LOAD_LATENCY > 1) begin
                     state_n = LOAD_STALL;
                     cnt_n   = LOAD_INIT;
                  end
               end
            end
            REDIRECT: begin
               o_ifid_flush = 1'b1;
               o_idex_flush = 1'b1;
               cnt_n        = eff_cnt - CNT_ONE;
               if (eff_cnt == CNT_ONE) begin
                  state_n = RUN;
                  cnt_n   = '0;
               end
            end
            LOAD_STALL: begin
               o_pc_hold    = 1'b1;
               o_ifid_stall = 1'b1;
               o_idex_flush = 1'b1;
               cnt_n        = eff_cnt - CNT_ONE;
               if (eff_cnt == CNT_ONE) begin
                  state_n = RUN;
                  cnt_n   = '0;
               end
            end
            default: begin
               state_n = RUN;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= RUN;
         cnt         <= '0;
         saved_state <= RUN;
         saved_cnt   <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         saved_state <= saved_state_n;
         saved_cnt   <= saved_cnt_n;
      end
   end

   assign o_state = state;

`ifdef PIPELINE_HAZARD_PERF_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_stall_cycles <= '0;
         o_flush_cycles <= '0;
      end else begin
         if (o_pc_hold)    o_stall_cycles <= o_stall_cycles + 32'd1;
         if (o_idex_flush) o_flush_cycles <= o_flush_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut uses FLUSH_DEPTH=2/LOAD_LATENCY=2, u1 uses 1/1, both share stimulus.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       take_branch = 1'b0, trap_req = 1'b0, trap_mret = 1'b0, mem_busy = 1'b0;
   logic       ex_is_load = 1'b0, ex_we = 1'b0, rs1_used = 1'b0, rs2_used = 1'b0;
   logic [4:0] ex_rd = '0, rs1 = '0, rs2 = '0;

   logic       m_pc_hold, m_ifid_stall, m_ifid_flush, m_idex_stall, m_idex_flush;
   logic [1:0] m_state;
   logic       s_pc_hold, s_ifid_stall, s_ifid_flush, s_idex_stall, s_idex_flush;
   logic [1:0] s_state;
`ifdef PIPELINE_HAZARD_PERF_EN
   logic [31:0] m_stall_cycles, m_flush_cycles, s_stall_cycles, s_flush_cycles;
`endif

   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned exp_stall = 0;
   int unsigned exp_flush = 0;

   // Expected-output encoding: {state[1:0], pc_hold, ifid_stall, ifid_flush, idex_stall, idex_flush}
   localparam logic [4:0] O_NO  = 5'b00000;
   localparam logic [4:0] O_FL  = 5'b00101;
   localparam logic [4:0] O_HZ  = 5'b11001;
   localparam logic [4:0] O_BZ  = 5'b11010;
   localparam logic [4:0] O_RST = 5'b10101;

   logic [6:0] obs_m, obs_s;
   assign obs_m = {m_state, m_pc_hold, m_ifid_stall, m_ifid_flush, m_idex_stall, m_idex_flush};
   assign obs_s = {s_state, s_pc_hold, s_ifid_stall, s_ifid_flush, s_idex_stall, s_idex_flush};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.FLUSH_DEPTH(2), .LOAD_LATENCY(2), .REG_ADDR_WIDTH(5)) dut (
      .i_clk(clk), .i_rst(rst), .i_take_branch(take_branch), .i_trap_req(trap_req),
      .i_trap_mret(trap_mret), .i_mem_busy(mem_busy), .i_ex_is_load(ex_is_load),
      .i_ex_regfile_we(ex_we), .i_ex_rd_addr(ex_rd), .i_id_rs1_used(rs1_used),
      .i_id_rs2_used(rs2_used), .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
      .o_pc_hold(m_pc_hold), .o_ifid_stall(m_ifid_stall), .o_ifid_flush(m_ifid_flush),
      .o_idex_stall(m_idex_stall), .o_idex_flush(m_idex_flush),
`ifdef PIPELINE_HAZARD_PERF_EN
      .o_stall_cycles(m_stall_cycles), .o_flush_cycles(m_flush_cycles),
`endif
      .o_state(m_state)
   );

   pipeline_hazard_ctrl #(.FLUSH_DEPTH(1), .LOAD_LATENCY(1), .REG_ADDR_WIDTH(5)) u1 (
      .i_clk(clk), .i_rst(rst), .i_take_branch(take_branch), .i_trap_req(trap_req),
      .i_trap_mret(trap_mret), .i_mem_busy(mem_busy), .i_ex_is_load(ex_is_load),
      .i_ex_regfile_we(ex_we), .i_ex_rd_addr(ex_rd), .i_id_rs1_used(rs1_used),
      .i_id_rs2_used(rs2_used), .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
      .o_pc_hold(s_pc_hold), .o_ifid_stall(s_ifid_stall), .o_ifid_flush(s_ifid_flush),
      .o_idex_stall(s_idex_stall), .o_idex_flush(s_idex_flush),
`ifdef PIPELINE_HAZARD_PERF_EN
      .o_stall_cycles(s_stall_cycles), .o_flush_cycles(s_flush_cycles),
`endif
      .o_state(s_state)
   );

   task automatic clr();
      take_branch = 1'b0; trap_req = 1'b0; trap_mret = 1'b0; mem_busy = 1'b0;
      ex_is_load = 1'b0; ex_we = 1'b0; ex_rd = '0;
      rs1_used = 1'b0; rs2_used = 1'b0; rs1 = '0; rs2 = '0;
   endtask

   task automatic load_use(input logic [4:0] rd);
      ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = rd;
      rs2_used = 1'b1; rs2 = rd; rs1_used = 1'b1; rs1 = 5'd7;
   endtask

   // Compare both instances this cycle, then advance to just after the next rising edge.
   task automatic cyc(input string tag, input logic [6:0] em, input logic [6:0] es);
      #1;
      checks++;
      assert (obs_m === em) else begin
         failures++;
         $error("FAIL %s dut got=%b exp=%b", tag, obs_m, em);
      end
      checks++;
      assert (obs_s === es) else begin
         failures++;
         $error("FAIL %s u1 got=%b exp=%b", tag, obs_s, es);
      end
      if (rst) begin
         exp_stall = 0;
         exp_flush = 0;
      end else begin
         if (em[4]) exp_stall++;
         if (em[0]) exp_flush++;
      end
      @(posedge clk);
      #1;
   endtask

`ifdef PIPELINE_HAZARD_PERF_EN
   task automatic perf_chk(input string tag);
      checks++;
      assert (m_stall_cycles === exp_stall) else begin
         failures++;
         $error("FAIL %s stall_cycles got=%0d exp=%0d", tag, m_stall_cycles, exp_stall);
      end
      checks++;
      assert (m_flush_cycles === exp_flush) else begin
         failures++;
         $error("FAIL %s flush_cycles got=%0d exp=%0d", tag, m_flush_cycles, exp_flush);
      end
   endtask
`endif

   initial begin
      clr();
      @(posedge clk);
      #1;
      cyc("reset", {2'd0, O_RST}, {2'd0, O_RST});
      rst = 1'b0;
      cyc("idle", {2'd0, O_NO}, {2'd0, O_NO});

      load_use(5'd5);
      cyc("lu_c1", {2'd0, O_HZ}, {2'd0, O_HZ});
      clr();
      cyc("lu_c2", {2'd2, O_HZ}, {2'd0, O_NO});
      cyc("lu_done", {2'd0, O_NO}, {2'd0, O_NO});

      load_use(5'd0);
      cyc("lu_rd0", {2'd0, O_NO}, {2'd0, O_NO});
      clr();

      take_branch = 1'b1;
      cyc("br_c1", {2'd0, O_FL}, {2'd0, O_FL});
      cyc("br_c2", {2'd1, O_FL}, {2'd0, O_FL});
      clr();
      cyc("br_c3", {2'd0, O_NO}, {2'd0, O_NO});

      load_use(5'd9);
      cyc("ls_haz", {2'd0, O_HZ}, {2'd0, O_HZ});
      clr();
      mem_busy = 1'b1;
      cyc("busy1", {2'd2, O_BZ}, {2'd0, O_BZ});
      cyc("busy2", {2'd3, O_BZ}, {2'd3, O_BZ});
      cyc("busy3", {2'd3, O_BZ}, {2'd3, O_BZ});
      mem_busy = 1'b0;
      cyc("busy_restore", {2'd3, O_HZ}, {2'd3, O_NO});
      cyc("busy_run", {2'd0, O_NO}, {2'd0, O_NO});

      trap_req = 1'b1; mem_busy = 1'b1; load_use(5'd3);
      cyc("trap_prio", {2'd0, O_FL}, {2'd0, O_FL});
      clr();
      cyc("trap_c2", {2'd1, O_FL}, {2'd0, O_NO});
      cyc("trap_done", {2'd0, O_NO}, {2'd0, O_NO});

      take_branch = 1'b1;
      cyc("rst_cnt_br", {2'd0, O_FL}, {2'd0, O_FL});
      take_branch = 1'b0; trap_mret = 1'b1;
      cyc("rst_cnt_mret", {2'd1, O_FL}, {2'd0, O_FL});
      clr();
      cyc("rst_cnt_c3", {2'd1, O_FL}, {2'd0, O_NO});
      cyc("rst_cnt_done", {2'd0, O_NO}, {2'd0, O_NO});

      mem_busy = 1'b1;
      cyc("mw_busy", {2'd0, O_BZ}, {2'd0, O_BZ});
      trap_req = 1'b1;
      cyc("mw_trap", {2'd3, O_FL}, {2'd3, O_FL});
      clr();
      cyc("mw_redir", {2'd1, O_FL}, {2'd0, O_NO});
      cyc("mw_done", {2'd0, O_NO}, {2'd0, O_NO});

`ifdef PIPELINE_HAZARD_PERF_EN
      perf_chk("perf_total");
`endif

      take_branch = 1'b1;
      cyc("pre_rst_br", {2'd0, O_FL}, {2'd0, O_FL});
      clr();
      rst = 1'b1;
      cyc("rst_mid_redir", {2'd0, O_RST}, {2'd0, O_RST});
      rst = 1'b0;
      cyc("post_rst", {2'd0, O_NO}, {2'd0, O_NO});

`ifdef PIPELINE_HAZARD_PERF_EN
      perf_chk("perf_after_rst");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
